mem_bus_arbiter: RTL and testbench

Two-port arbiter that lets the instruction cache and the data cache share the single main-memory block port. It sits between the icache/dcache miss interfaces and the data-memory model, and sequences one block transfer at a time. It returns a per-cache busywait, so the CPU's existing stall logic (BUSYWAITI/BUSYWAITD) works unchanged. On contention it grants the two caches round-robin; neither can starve the other.

---
 rtl/mem_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single main-memory block port between the icache
// and dcache, one block transfer at a time, round-robin on contention.
//
// state   | meaning
// IDLE    | no transfer in flight; arbitrate between pending requests
// GRANT_I | icache transfer issued to memory, waiting for it to finish
// GRANT_D | dcache transfer issued to memory, waiting for it to finish
// DONE_I  | icache transfer finished; I_BUSYWAIT released for one cycle
// DONE_D  | dcache transfer finished; D_BUSYWAIT released for one cycle
module mem_bus_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D} state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: dcache was served last
  logic              started_q, started_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;
  logic [DATA_W-1:0] i_readdata_q, i_readdata_d;
  logic [DATA_W-1:0] d_readdata_q, d_readdata_d;

  logic i_req, d_req, grant_d;

  assign i_req   = I_READ;
  assign d_req   = D_READ | D_WRITE;
  assign grant_d = d_req & (~i_req | ~last_d_q);

  always_comb begin
    state_d         = state_q;
    last_d_d        = last_d_q;
    started_d       = started_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    i_readdata_d    = i_readdata_q;
    d_readdata_d    = d_readdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d         = GRANT_D;
          mem_read_d      = ~D_WRITE;
          mem_write_d     = D_WRITE;
          mem_address_d   = D_ADDRESS;
          mem_writedata_d = D_WRITEDATA;
          started_d       = 1'b0;
        end else if (i_req) begin
          state_d       = GRANT_I;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = I_ADDRESS;
          started_d     = 1'b0;
        end
      end
      GRANT_I, GRANT_D: begin
        // Completion needs busywait seen high first, then low.
        if (MEM_BUSYWAIT) begin
          started_d = 1'b1;
        end else if (started_q) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          last_d_d    = (state_q == GRANT_D);
          if (state_q == GRANT_D) begin
            if (mem_read_q) d_readdata_d = MEM_READDATA;
            state_d = d_req ? DONE_D : IDLE;
          end else begin
            if (mem_read_q) i_readdata_d = MEM_READDATA;
            state_d = i_req ? DONE_I : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= IDLE;
      last_d_q        <= 1'b0;
      started_q       <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      i_readdata_q    <= '0;
      d_readdata_q    <= '0;
    end else begin
      state_q         <= state_d;
      last_d_q        <= last_d_d;
      started_q       <= started_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      i_readdata_q    <= i_readdata_d;
      d_readdata_q    <= d_readdata_d;
    end
  end

  assign I_BUSYWAIT    = i_req & (state_q != DONE_I);
  assign D_BUSYWAIT    = d_req & (state_q != DONE_D);
  assign I_READDATA    = i_readdata_q;
  assign D_READDATA    = d_readdata_q;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_address_q;
  assign MEM_WRITEDATA = mem_writedata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: random and directed cache traffic
// against a latency-randomised memory model and a reference memory image.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read, i_busywait;
  logic [5:0]  i_address;
  logic [31:0] i_readdata;
  logic        d_read, d_write, d_busywait;
  logic [5:0]  d_address;
  logic [31:0] d_writedata, d_readdata;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        mem_busywait = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .CLK(clk), .RESET(reset),
    .I_READ(i_read), .I_ADDRESS(i_address), .I_READDATA(i_readdata), .I_BUSYWAIT(i_busywait),
    .D_READ(d_read), .D_WRITE(d_write), .D_ADDRESS(d_address), .D_WRITEDATA(d_writedata),
    .D_READDATA(d_readdata), .D_BUSYWAIT(d_busywait),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write), .MEM_ADDRESS(mem_address),
    .MEM_WRITEDATA(mem_writedata), .MEM_READDATA(mem_readdata), .MEM_BUSYWAIT(mem_busywait)
  );

  int checks = 0;
  int errors = 0;
  int to_cnt = 0;
  int to_seen = 0;
  int lat_force = 0;

  logic [31:0] ref_mem [64];
  logic [31:0] d_rd_model = '0;
  logic [31:0] i_q [$];
  logic [31:0] d_q [$];

  function automatic logic [31:0] init_val(input int a);
    return (a == 5) ? 32'hA1B2C3D4 : 32'h1000_0000 + 32'(a) * 32'h0101_0101;
  endfunction

  // Memory model: busy for a chosen number of cycles per command, then
  // ignores the command until it has been seen low once.
  logic [31:0] mem_array [64];
  bit          mem_inited = 1'b0;
  bit          m_active = 1'b0, m_done = 1'b0, m_wr = 1'b0;
  int          m_cnt = 0;
  logic [5:0]  m_addr = '0;
  logic [31:0] m_wdata = '0;
  int          since_fin = 99;

  always @(posedge clk) begin : mem_model
    int lat;
    if (!mem_inited) begin
      for (int k = 0; k < 64; k++) mem_array[k] = init_val(k);
      mem_inited = 1'b1;
    end
    if (reset) begin
      mem_busywait <= 1'b0;
      m_active = 1'b0;
      m_done   = 1'b0;
      since_fin <= 99;
    end else begin
      if (since_fin < 99) since_fin <= since_fin + 1;
      if (m_active) begin
        if (m_cnt == 1) begin
          mem_busywait <= 1'b0;
          m_active = 1'b0;
          m_done   = 1'b1;
          since_fin <= 0;
          if (m_wr) mem_array[m_addr] = m_wdata;
          else mem_readdata <= mem_array[m_addr];
        end else begin
          m_cnt = m_cnt - 1;
        end
      end else if (m_done) begin
        if (!(mem_read | mem_write)) m_done = 1'b0;
      end else if (mem_read | mem_write) begin
        lat = (lat_force != 0) ? lat_force : int'($urandom_range(1, 6));
        m_active = 1'b1;
        m_cnt    = lat;
        m_addr   = mem_address;
        m_wr     = mem_write;
        m_wdata  = mem_writedata;
        mem_busywait <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: predicts grants from the round-robin rule, release of busywait
  // from memory completion, and pops expected read data on each release.
  logic       last_w = 1'b0;   // 1: dcache served last
  logic       prev_i = 1'b0, prev_d = 1'b0, cmd_prev = 1'b0, prev_reset = 1'b0;
  logic       exp_grant = 1'b0, exp_rd = 1'b0, exp_wr = 1'b0;
  logic [5:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;

  always @(negedge clk) begin : monitor
    logic cur_i, cur_d, cmd_now, done_i, done_d, win_d;
    logic [31:0] e;
    cur_i   = i_read;
    cur_d   = d_read | d_write;
    cmd_now = mem_read | mem_write;
    if (to_cnt != to_seen) begin
      checks++;
      errors++;
      $display("FAIL busywait_timeout: got %0d expired waits, required 0", to_cnt - to_seen);
      to_seen = to_cnt;
    end
    if (reset) begin
      last_w     = 1'b0;
      cmd_prev   = 1'b0;
      exp_grant  = 1'b0;
      prev_reset = 1'b1;
      prev_i     = cur_i;
      prev_d     = cur_d;
    end else begin
      if (prev_reset) begin
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_i_readdata", i_readdata, 32'd0);
        check("rst_d_readdata", d_readdata, 32'd0);
      end
      done_i = (since_fin == 1) && !last_w && prev_i;
      done_d = (since_fin == 1) && last_w && prev_d;
      check("i_busywait", 32'(i_busywait), 32'(cur_i && !done_i));
      check("d_busywait", 32'(d_busywait), 32'(cur_d && !done_d));
      if (done_i) begin
        if (i_q.size() == 0) check("i_done_unexpected", 32'(1), 32'(0));
        else begin e = i_q.pop_front(); check("i_readdata", i_readdata, e); end
      end
      if (done_d) begin
        if (d_q.size() == 0) check("d_done_unexpected", 32'(1), 32'(0));
        else begin e = d_q.pop_front(); check("d_readdata", d_readdata, e); end
      end
      if (exp_grant) begin
        check("grant_start", 32'(cmd_now && !cmd_prev), 32'd1);
        check("grant_mem_read", 32'(mem_read), 32'(exp_rd));
        check("grant_mem_write", 32'(mem_write), 32'(exp_wr));
        check("grant_mem_address", 32'(mem_address), 32'(exp_addr));
        if (exp_wr) check("grant_mem_writedata", mem_writedata, exp_wdata);
      end else if (cmd_now && !cmd_prev) begin
        check("grant_unexpected", 32'(cmd_now), 32'd0);
      end else if (cmd_now) begin
        check("hold_mem_read", 32'(mem_read), 32'(exp_rd));
        check("hold_mem_write", 32'(mem_write), 32'(exp_wr));
        check("hold_mem_address", 32'(mem_address), 32'(exp_addr));
        if (exp_wr) check("hold_mem_writedata", mem_writedata, exp_wdata);
      end
      exp_grant = !cmd_now && !done_i && !done_d && (cur_i || cur_d);
      if (exp_grant) begin
        win_d     = cur_d && (!cur_i || !last_w);
        last_w    = win_d;
        exp_rd    = win_d ? !d_write : 1'b1;
        exp_wr    = win_d ? d_write : 1'b0;
        exp_addr  = win_d ? d_address : i_address;
        exp_wdata = d_writedata;
      end
      cmd_prev   = cmd_now;
      prev_i     = cur_i;
      prev_d     = cur_d;
      prev_reset = 1'b0;
    end
  end

  task automatic i_txn(input logic [5:0] a);
    int n = 0;
    i_address = a;
    i_read    = 1'b1;
    i_q.push_back(ref_mem[a]);
    do begin @(negedge clk); n++; end while (i_busywait && n < 100);
    if (i_busywait) to_cnt++;
    @(posedge clk); #1;
    i_read = 1'b0;
  endtask

  task automatic d_txn(input logic wr, input logic both, input logic [5:0] a, input logic [31:0] data);
    int n = 0;
    d_address   = a;
    d_writedata = data;
    d_write     = wr;
    d_read      = wr ? both : 1'b1;
    if (wr) ref_mem[a] = data;
    else d_rd_model = ref_mem[a];
    d_q.push_back(d_rd_model);
    do begin @(negedge clk); n++; end while (d_busywait && n < 100);
    if (d_busywait) to_cnt++;
    @(posedge clk); #1;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic wait_mem_busy();
    int n = 0;
    do begin @(negedge clk); n++; end while (!mem_busywait && n < 50);
    if (!mem_busywait) to_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    d_rd_model = '0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
    for (int k = 0; k < 64; k++) ref_mem[k] = init_val(k);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // lone icache read and lone dcache write
    lat_force = 5;
    i_txn(6'h05);
    repeat (2) begin @(posedge clk); #1; end
    lat_force = 3;
    d_txn(1'b1, 1'b0, 6'h3F, 32'hDEADBEEF);
    repeat (2) begin @(posedge clk); #1; end

    // simultaneous first request after reset: dcache first
    do_reset();
    lat_force = 4;
    fork
      i_txn(6'h07);
      d_txn(1'b0, 1'b0, 6'h14, 32'h0);
    join

    // sustained contention: D,I,D,I,D,I
    lat_force = 2;
    fork
      for (int k = 0; k < 3; k++) i_txn(6'(k + 1));
      for (int k = 0; k < 3; k++) d_txn(1'(k % 2), 1'b0, 6'(40 + k), 32'hC0DE_0000 + 32'(k));
    join
    repeat (2) begin @(posedge clk); #1; end

    // reset in the middle of a dcache transfer, then a normal icache read
    lat_force = 8;
    fork
      d_txn(1'b0, 1'b0, 6'h0A, 32'h0);
      begin
        wait_mem_busy();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        d_rd_model = ref_mem[6'h0A];
      end
    join
    lat_force = 3;
    i_txn(6'h0C);
    repeat (2) begin @(posedge clk); #1; end

    // icache abandons its request mid-transfer; pending dcache read goes next
    lat_force = 6;
    fork
      begin
        i_address = 6'h03;
        i_read    = 1'b1;
        wait_mem_busy();
        i_read = 1'b0;
      end
      begin
        @(posedge clk); #1;
        d_txn(1'b0, 1'b0, 6'h21, 32'h0);
      end
    join
    repeat (3) begin @(posedge clk); #1; end

    // randomised traffic
    lat_force = 0;
    fork
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        i_txn(6'($urandom_range(0, 31)));
      end
      for (int k = 0; k < 25; k++) begin
        logic wr;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        wr = 1'($urandom_range(0, 1));
        d_txn(wr, 1'($urandom_range(0, 1)),
              wr ? 6'(32 + $urandom_range(0, 31)) : 6'($urandom_range(0, 63)),
              32'($urandom));
      end
    join

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
